// File: rtl/ysyx_210544_if_axi_rd.sv
// Instruction-fetch AXI read master: one 32-bit fetch per request,
// issued as a single-beat 64-bit AXI read with lane selection on addr[2].
module ysyx_210544_if_axi_rd #(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_bus_req,
    input  logic [63:0] i_bus_addr,
    output logic        o_bus_ack,
    output logic [31:0] o_bus_rdata,
    output logic        o_bus_err,

    output logic        o_axi_ar_valid,
    input  logic        i_axi_ar_ready,
    output logic [63:0] o_axi_ar_addr,
    output logic [3:0]  o_axi_ar_id,
    output logic [7:0]  o_axi_ar_len,
    output logic [2:0]  o_axi_ar_size,
    output logic [1:0]  o_axi_ar_burst,

    input  logic        i_axi_r_valid,
    output logic        o_axi_r_ready,
    input  logic [63:0] i_axi_r_data,
    input  logic [1:0]  i_axi_r_resp,
    input  logic        i_axi_r_last,
    input  logic [3:0]  i_axi_r_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // Single outstanding beat: last and id carry no extra information.
    logic unused_r_sideband;
    assign unused_r_sideband = ^{i_axi_r_last, i_axi_r_id};

    // Fixed single-beat, 4-byte, INCR read attributes.
    assign o_axi_ar_id    = AXI_ID;
    assign o_axi_ar_len   = 8'd0;
    assign o_axi_ar_size  = 3'b010;
    assign o_axi_ar_burst = 2'b01;

    assign o_axi_ar_valid = ar_valid_q;
    assign o_axi_ar_addr  = addr_q;
    assign o_axi_r_ready  = r_ready_q;
    assign o_bus_ack      = ack_q;
    assign o_bus_rdata    = rdata_q;
    assign o_bus_err      = err_q;

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        ack_d      = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_bus_req) begin
                    addr_d     = i_bus_addr;
                    ar_valid_d = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (i_axi_ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (i_axi_r_valid) begin
                    r_ready_d = 1'b0;
                    rdata_d   = addr_q[2] ? i_axi_r_data[63:32]
                                          : i_axi_r_data[31:0];
                    err_d     = (i_axi_r_resp != 2'b00);
                    ack_d     = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 64'd0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_210544_if_axi_rd.sv
// Self-checking bench for the fetch AXI read master: directed cases
// plus randomized fetches against a transaction-level expectation.
module tb_ysyx_210544_if_axi_rd;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_bus_req;
    logic [63:0] i_bus_addr;
    logic        o_bus_ack;
    logic [31:0] o_bus_rdata;
    logic        o_bus_err;
    logic        o_axi_ar_valid;
    logic        i_axi_ar_ready;
    logic [63:0] o_axi_ar_addr;
    logic [3:0]  o_axi_ar_id;
    logic [7:0]  o_axi_ar_len;
    logic [2:0]  o_axi_ar_size;
    logic [1:0]  o_axi_ar_burst;
    logic        i_axi_r_valid;
    logic        o_axi_r_ready;
    logic [63:0] i_axi_r_data;
    logic [1:0]  i_axi_r_resp;
    logic        i_axi_r_last;
    logic [3:0]  i_axi_r_id;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;
    int n_fetch  = 0;

    ysyx_210544_if_axi_rd #(.AXI_ID(4'h0)) dut (
        .clk(clk), .rst(rst),
        .i_bus_req(i_bus_req), .i_bus_addr(i_bus_addr),
        .o_bus_ack(o_bus_ack), .o_bus_rdata(o_bus_rdata),
        .o_bus_err(o_bus_err),
        .o_axi_ar_valid(o_axi_ar_valid), .i_axi_ar_ready(i_axi_ar_ready),
        .o_axi_ar_addr(o_axi_ar_addr), .o_axi_ar_id(o_axi_ar_id),
        .o_axi_ar_len(o_axi_ar_len), .o_axi_ar_size(o_axi_ar_size),
        .o_axi_ar_burst(o_axi_ar_burst),
        .i_axi_r_valid(i_axi_r_valid), .o_axi_r_ready(o_axi_r_ready),
        .i_axi_r_data(i_axi_r_data), .i_axi_r_resp(i_axi_r_resp),
        .i_axi_r_last(i_axi_r_last), .i_axi_r_id(i_axi_r_id)
    );

    always #5 clk = ~clk;

    // Channel exclusivity and ack pulse counting, sampled mid-cycle.
    always @(negedge clk) begin
        checks++;
        assert (!(o_axi_ar_valid && o_axi_r_ready)) else begin
            failures++;
            $error("FAIL ar_r_overlap observed=1 expected=0");
        end
        if (o_bus_ack) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch: requester plus AXI slave, with the expected bus result
    // derived from the lane-select and error rules.
    task automatic fetch(input logic [63:0] a, input int ars, input int rs,
                         input logic [63:0] d, input logic [1:0] resp,
                         input bit keep);
        logic [31:0] er;
        logic        ee;
        er = a[2] ? d[63:32] : d[31:0];
        ee = (resp != 2'b00);
        i_bus_req      = 1'b1;
        i_bus_addr     = a;
        i_axi_ar_ready = 1'b0;
        i_axi_r_valid  = 1'b0;
        step();
        if (!keep) i_bus_req = 1'b0;
        i_bus_addr = a ^ 64'h1000;
        chk("ar_valid_set", {63'd0, o_axi_ar_valid}, 64'd1);
        chk("ar_addr", o_axi_ar_addr, a);
        chk("r_ready_addr", {63'd0, o_axi_r_ready}, 64'd0);
        repeat (ars) begin
            step();
            chk("ar_hold_valid", {63'd0, o_axi_ar_valid}, 64'd1);
            chk("ar_hold_addr", o_axi_ar_addr, a);
            chk("no_ack_addr", {63'd0, o_bus_ack}, 64'd0);
        end
        i_axi_ar_ready = 1'b1;
        step();
        i_axi_ar_ready = 1'b0;
        chk("ar_valid_drop", {63'd0, o_axi_ar_valid}, 64'd0);
        chk("r_ready_set", {63'd0, o_axi_r_ready}, 64'd1);
        chk("no_ack_data", {63'd0, o_bus_ack}, 64'd0);
        repeat (rs) begin
            step();
            chk("r_ready_hold", {63'd0, o_axi_r_ready}, 64'd1);
            chk("no_ack_rstall", {63'd0, o_bus_ack}, 64'd0);
        end
        i_axi_r_valid = 1'b1;
        i_axi_r_data  = d;
        i_axi_r_resp  = resp;
        i_axi_r_last  = 1'b1;
        i_axi_r_id    = 4'($urandom);
        step();
        i_axi_r_valid = 1'b0;
        i_axi_r_data  = {$urandom, $urandom};
        i_axi_r_resp  = 2'($urandom);
        chk("ack", {63'd0, o_bus_ack}, 64'd1);
        chk("rdata", {32'd0, o_bus_rdata}, {32'd0, er});
        chk("err", {63'd0, o_bus_err}, {63'd0, ee});
        chk("r_ready_drop", {63'd0, o_axi_r_ready}, 64'd0);
        step();
        chk("ack_width", {63'd0, o_bus_ack}, 64'd0);
        chk("rdata_hold", {32'd0, o_bus_rdata}, {32'd0, er});
        chk("err_hold", {63'd0, o_bus_err}, {63'd0, ee});
        n_fetch++;
    endtask

    initial begin
        rst            = 1'b1;
        i_bus_req      = 1'b1;
        i_bus_addr     = 64'h8000_0010;
        i_axi_ar_ready = 1'b1;
        i_axi_r_valid  = 1'b0;
        i_axi_r_data   = 64'd0;
        i_axi_r_resp   = 2'b00;
        i_axi_r_last   = 1'b0;
        i_axi_r_id     = 4'd0;
        step();
        step();
        chk("rst_ack", {63'd0, o_bus_ack}, 64'd0);
        chk("rst_ar_valid", {63'd0, o_axi_ar_valid}, 64'd0);
        chk("rst_r_ready", {63'd0, o_axi_r_ready}, 64'd0);
        chk("rst_ar_addr", o_axi_ar_addr, 64'd0);
        chk("rst_rdata", {32'd0, o_bus_rdata}, 64'd0);
        chk("rst_err", {63'd0, o_bus_err}, 64'd0);
        chk("rst_ar_len", {56'd0, o_axi_ar_len}, 64'd0);
        chk("rst_ar_size", {61'd0, o_axi_ar_size}, 64'd2);
        chk("rst_ar_burst", {62'd0, o_axi_ar_burst}, 64'd1);
        chk("rst_ar_id", {60'd0, o_axi_ar_id}, 64'd0);
        i_bus_req = 1'b0;
        rst = 1'b0;
        step();
        chk("idle_ar_valid", {63'd0, o_axi_ar_valid}, 64'd0);

        // Zero-wait, upper lane.
        fetch(64'h8000_0004, 0, 0, 64'h0000_0013_DEAD_BEEF, 2'b00, 1'b0);
        // AR stall of 5 cycles, address changed while in ADDR.
        fetch(64'h8000_0000, 5, 0, 64'hCAFE_F00D_1234_5678, 2'b00, 1'b0);
        // Lower lane with slave error.
        fetch(64'h8000_0000, 0, 0, 64'h1111_1111_2222_2222, 2'b10, 1'b0);
        // R-channel stall.
        fetch(64'h8000_0104, 1, 4, 64'hA5A5_A5A5_5A5A_5A5A, 2'b11, 1'b0);
        // Back-to-back with request held high.
        fetch(64'h8000_0000, 0, 0, 64'h0102_0304_0506_0708, 2'b00, 1'b1);
        fetch(64'h8000_0004, 0, 0, 64'h1112_1314_1516_1718, 2'b00, 1'b1);
        i_bus_req = 1'b0;
        step();
        step();

        // Reset during DATA abandons the fetch.
        i_bus_req  = 1'b1;
        i_bus_addr = 64'h8000_0204;
        step();
        i_bus_req      = 1'b0;
        i_axi_ar_ready = 1'b1;
        step();
        i_axi_ar_ready = 1'b0;
        chk("mid_r_ready", {63'd0, o_axi_r_ready}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_r_ready", {63'd0, o_axi_r_ready}, 64'd0);
        chk("mid_rst_ack", {63'd0, o_bus_ack}, 64'd0);
        chk("mid_rst_rdata", {32'd0, o_bus_rdata}, 64'd0);
        chk("mid_rst_ar_addr", o_axi_ar_addr, 64'd0);
        fetch(64'h8000_0300, 0, 0, 64'h9999_8888_7777_6666, 2'b00, 1'b0);

        // Randomized fetches.
        for (int i = 0; i < 24; i++) begin
            logic [63:0] a;
            a = {32'd0, 32'h8000_0000 | (32'($urandom_range(0, 4095)) << 2)};
            fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 2'($urandom), 1'($urandom));
        end
        i_bus_req = 1'b0;
        step();
        step();
        chk("ack_pulse_count", 64'(ack_cnt), 64'(n_fetch));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_210544_if_axi_rd.md
YSYX_210544_IF_AXI_RD -- requirements
Module: ysyx_210544_if_axi_rd

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0, meaning the value driven on o_axi_ar_id.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_bus_req, input, 1, fetch request from the fetch unit.
REQ-006 SHALL have port i_bus_addr, input, 64, fetch byte address (4-byte aligned).
REQ-007 SHALL have port o_bus_ack, output, 1, one-cycle fetch-complete pulse.
REQ-008 SHALL have port o_bus_rdata, output, 32, fetched instruction word.
REQ-009 SHALL have port o_bus_err, output, 1, error flag valid with o_bus_ack.
REQ-010 SHALL have port o_axi_ar_valid, output, 1, AR channel valid.
REQ-011 SHALL have port i_axi_ar_ready, input, 1, AR channel ready.
REQ-012 SHALL have port o_axi_ar_addr, output, 64, read address.
REQ-013 SHALL have ports o_axi_ar_id (4), o_axi_ar_len (8), o_axi_ar_size (3) and o_axi_ar_burst (2), all outputs.
REQ-014 SHALL have ports i_axi_r_valid (in, 1), o_axi_r_ready (out, 1), i_axi_r_data (in, 64), i_axi_r_resp (in, 2), i_axi_r_last (in, 1) and i_axi_r_id (in, 4).

Function
REQ-015 SHALL implement an FSM with the states IDLE, ADDR, DATA and ACK.
REQ-016 SHALL, in IDLE with i_bus_req=1, capture i_bus_addr into an internal register and enter ADDR on the next cycle.
REQ-017 SHALL, in ADDR, drive o_axi_ar_valid=1 with o_axi_ar_addr equal to the captured address, holding both stable until i_axi_ar_ready=1.
REQ-018 SHALL enter DATA on the cycle after the AR handshake (valid&ready), and SHALL deassert o_axi_ar_valid in that cycle.
REQ-019 SHALL drive the AR constants o_axi_ar_len=0, o_axi_ar_size=3'b010, o_axi_ar_burst=2'b01 and o_axi_ar_id=AXI_ID at all times, including during reset.
REQ-020 SHALL, in DATA, drive o_axi_r_ready=1; at all other times o_axi_r_ready SHALL be 0.
REQ-021 SHALL, on the R handshake, latch o_bus_rdata = the captured addr[2] ? i_axi_r_data[63:32] : i_axi_r_data[31:0].
REQ-022 SHALL, on the R handshake, latch o_bus_err = (i_axi_r_resp != 2'b00), and enter ACK.
REQ-023 SHALL ignore i_axi_r_last and i_axi_r_id: there is a single outstanding transaction, and the first beat completes it.
REQ-024 SHALL, in ACK, drive o_bus_ack=1 for exactly one cycle and then return to IDLE.
REQ-025 SHALL hold o_bus_rdata and o_bus_err until the next R handshake.
REQ-026 SHALL treat i_bus_req=1 in the cycle after ACK (IDLE) as a new request, so back-to-back fetches are legal.
REQ-027 SHALL ignore changes of i_bus_req and i_bus_addr outside IDLE; the captured address governs the transaction in flight.
REQ-028 SHALL have a minimum latency of 3 cycles from a sampled request to o_bus_ack (ar_ready and r_valid both high immediately), and SHALL allow unbounded stalls on either channel.
REQ-029 SHALL never drive o_axi_ar_valid and o_axi_r_ready high in the same cycle.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, enter IDLE and clear o_bus_ack, o_bus_err, o_bus_rdata, o_axi_ar_valid, o_axi_r_ready, o_axi_ar_addr and the captured address to 0.
REQ-031 SHALL, on rst asserted mid-transaction (ADDR or DATA), abandon the transaction with no o_bus_ack; the AXI slave is reset by the same signal.
REQ-032 SHALL sample i_bus_req only from the first cycle after rst deasserts.

Verification
REQ-033 SHALL pass the zero-wait test: req with addr=0x80000004, ar_ready=1, r_valid=1 next cycle, r_data=0x00000013_DEADBEEF -> ar_addr=0x80000004; ack 3 cycles after req sampled; rdata=0x00000013; err=0.
REQ-034 SHALL pass the AR-stall test: ar_ready low for 5 cycles -> ar_valid stays high and ar_addr stays constant for 5 cycles; ack follows 2 cycles after the handshake.
REQ-035 SHALL pass the lower-lane/error test: addr=0x80000000, r_resp=2'b10, r_data=0x11111111_22222222 -> rdata=0x22222222, err=1 with the ack pulse.
REQ-036 SHALL pass the back-to-back test: req held high across two fetches at 0x80000000 and 0x80000004 -> two ack pulses, each exactly 1 cycle wide, with 2 AR handshakes in order.
REQ-037 SHALL pass the reset-mid-op test: rst asserted during DATA -> next cycle state IDLE, r_ready=0, ack=0, rdata=0; a subsequent req completes normally.
REQ-038 SHALL pass the address-change test: i_bus_addr changed from 0x80000000 to 0x80001000 during ADDR -> ar_addr remains 0x80000000.
